// File: rtl/execute_cycle.sv
// RV32 EX stage: operand forwarding, ALU, beq resolution, branch target, EX/MEM register.
// Optional feature macro: EXEC_FORWARD_EN (forwarding muxes); undefined means raw register-file operands.
module execute_cycle #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  ALUSrcE,
    input  logic                  MemWriteE,
    input  logic                  ResultSrcE,
    input  logic                  BranchE,
    input  logic [2:0]            ALUControlE,
    input  logic [DATA_W-1:0]     RD1_E,
    input  logic [DATA_W-1:0]     RD2_E,
    input  logic [DATA_W-1:0]     Imm_Ext_E,
    input  logic [REG_ADDR_W-1:0] RD_E,
    input  logic [DATA_W-1:0]     PCE,
    input  logic [DATA_W-1:0]     PCPlus4E,
    input  logic [DATA_W-1:0]     ResultW,
    input  logic [1:0]            ForwardA_E,
    input  logic [1:0]            ForwardB_E,
    output logic                  PCSrcE,
    output logic [DATA_W-1:0]     PCTargetE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic                  ResultSrcM,
    output logic [REG_ADDR_W-1:0] RD_M,
    output logic [DATA_W-1:0]     ALU_ResultM,
    output logic [DATA_W-1:0]     WriteDataM,
    output logic [DATA_W-1:0]     PCPlus4M
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [DATA_W-1:0]     src_a;
    logic [DATA_W-1:0]     src_b;
    logic [DATA_W-1:0]     write_data;
    logic [DATA_W-1:0]     alu_result;
    logic                  zero;

    logic                  reg_write_d,   reg_write_q;
    logic                  mem_write_d,   mem_write_q;
    logic                  result_src_d,  result_src_q;
    logic [REG_ADDR_W-1:0] rd_d,          rd_q;
    logic [DATA_W-1:0]     alu_result_d,  alu_result_q;
    logic [DATA_W-1:0]     write_data_d,  write_data_q;
    logic [DATA_W-1:0]     pc_plus4_d,    pc_plus4_q;

`ifdef EXEC_FORWARD_EN
    // Code 11 is unused by the hazard unit and falls back to the register-file value.
    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [DATA_W-1:0] rf_val,
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] mem_val
    );
        case (sel)
            2'b01:   fwd_sel = wb_val;
            2'b10:   fwd_sel = mem_val;
            default: fwd_sel = rf_val;
        endcase
    endfunction

    always_comb begin
        src_a      = fwd_sel(RD1_E, ForwardA_E, ResultW, alu_result_q);
        write_data = fwd_sel(RD2_E, ForwardB_E, ResultW, alu_result_q);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ForwardA_E, ForwardB_E, ResultW};

    always_comb begin
        src_a      = RD1_E;
        write_data = RD2_E;
    end
`endif

    always_comb begin
        src_b = ALUSrcE ? Imm_Ext_E : write_data;
    end

    always_comb begin
        alu_result = '0;
        case (ALUControlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
        zero = (alu_result == '0);
    end

    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + Imm_Ext_E;

    // No stall/flush: the EX/MEM register takes a new instruction (or bubble) every cycle.
    always_comb begin
        reg_write_d  = RegWriteE;
        mem_write_d  = MemWriteE;
        result_src_d = ResultSrcE;
        rd_d         = RD_E;
        alu_result_d = alu_result;
        write_data_d = write_data;
        pc_plus4_d   = PCPlus4E;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            rd_q         <= rd_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
        end
    end

    assign RegWriteM   = reg_write_q;
    assign MemWriteM   = mem_write_q;
    assign ResultSrcM  = result_src_q;
    assign RD_M        = rd_q;
    assign ALU_ResultM = alu_result_q;
    assign WriteDataM  = write_data_q;
    assign PCPlus4M    = pc_plus4_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: expected EX/MEM contents queued at drive time, popped after the edge.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    typedef struct {
        logic        rw, mw, rs;
        logic [4:0]  rd;
        logic [31:0] alu, wd, pc4;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_alu = 32'h0;
    int          errs = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [31:0] rf, input logic [1:0] sel);
`ifdef EXEC_FORWARD_EN
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return m_alu;
`endif
        return rf;
    endfunction

    function automatic logic [31:0] m_alu_op(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
            default: return 32'h0;
        endcase
    endfunction

    // Called #1 after a rising edge with inputs already applied; consumes one clock.
    task automatic step(input logic r);
        logic [31:0] sa, wd, sbv, res;
        exp_t e;
        rst = r;
        sa  = m_fwd(RD1_E, ForwardA_E);
        wd  = m_fwd(RD2_E, ForwardB_E);
        sbv = ALUSrcE ? Imm_Ext_E : wd;
        res = m_alu_op(sa, sbv, ALUControlE);
        #2;
        chk("pcsrc", {31'b0, PCSrcE}, {31'b0, BranchE && (res == 32'h0)});
        chk("pctarget", PCTargetE, PCE + Imm_Ext_E);
        if (r) e = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0};
        else   e = '{RegWriteE, MemWriteE, ResultSrcE, RD_E, res, wd, PCPlus4E};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            chk("RegWriteM",   {31'b0, RegWriteM},  {31'b0, e.rw});
            chk("MemWriteM",   {31'b0, MemWriteM},  {31'b0, e.mw});
            chk("ResultSrcM",  {31'b0, ResultSrcM}, {31'b0, e.rs});
            chk("RD_M",        {27'b0, RD_M},       {27'b0, e.rd});
            chk("ALU_ResultM", ALU_ResultM, e.alu);
            chk("WriteDataM",  WriteDataM,  e.wd);
            chk("PCPlus4M",    PCPlus4M,    e.pc4);
            m_alu = e.alu;
        end
    endtask

    task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic src);
        ALUControlE = op; RD1_E = a; RD2_E = b; Imm_Ext_E = imm; ALUSrcE = src;
        BranchE = 1'b0; MemWriteE = 1'b0; RegWriteE = 1'b1; ResultSrcE = 1'b0;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    endtask

    initial begin
        // Reset with nonzero inputs: beq of equal values keeps PCSrcE high combinationally.
        rst = 1'b1;
        RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1; BranchE = 1'b1; ALUSrcE = 1'b0;
        ALUControlE = 3'b001; RD1_E = 32'd9; RD2_E = 32'd9; Imm_Ext_E = 32'h10;
        RD_E = 5'd7; PCE = 32'h40; PCPlus4E = 32'h44; ResultW = 32'h55;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00;
        #1;
        step(1'b1);
        step(1'b1);

        set_op(3'b000, 32'd5, 32'd7, 32'h0, 1'b0); RD_E = 5'd3; PCPlus4E = 32'h104;
        step(1'b0);
        set_op(3'b101, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1);
        step(1'b0);
        set_op(3'b101, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1);
        step(1'b0);
        set_op(3'b001, 32'd9, 32'd9, 32'hFFFF_FFF8, 1'b0); BranchE = 1'b1; PCE = 32'h100;
        step(1'b0);
        set_op(3'b001, 32'd9, 32'd8, 32'hFFFF_FFF8, 1'b0); BranchE = 1'b1; PCE = 32'h4;
        step(1'b0);
        set_op(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h0, 1'b0); step(1'b0);
        set_op(3'b011, 32'hF000_0001, 32'h0000_0F00, 32'h0, 1'b0); step(1'b0);
        set_op(3'b100, 32'h1, 32'h2, 32'h0, 1'b0); BranchE = 1'b1; step(1'b0);
        set_op(3'b111, 32'h7, 32'h9, 32'h0, 1'b0); step(1'b0);

        // Back-to-back dependency through the EX/MEM register and the writeback path.
        set_op(3'b000, 32'd1, 32'd2, 32'h0, 1'b0); step(1'b0);
        set_op(3'b000, 32'd0, 32'd4, 32'h0, 1'b0); ForwardA_E = 2'b10; ForwardB_E = 2'b01;
        ResultW = 32'h55; step(1'b0);
        set_op(3'b000, 32'd6, 32'd1, 32'h0, 1'b0); ForwardA_E = 2'b11; ForwardB_E = 2'b11;
        step(1'b0);

        // Store in EX when reset hits, then resume.
        set_op(3'b000, 32'h20, 32'hDEAD, 32'h8, 1'b1); MemWriteE = 1'b1; RegWriteE = 1'b0;
        step(1'b1);
        step(1'b0);

        for (int i = 0; i < 40; i++) begin
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
            BranchE = 1'($urandom); ALUSrcE = 1'($urandom); ALUControlE = 3'($urandom);
            RD1_E = (i % 4 == 0) ? RD2_E : $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom;
            RD_E = 5'($urandom); PCE = $urandom; PCPlus4E = PCE + 32'd4; ResultW = $urandom;
            ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
            step(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
